blockade_outport: RTL and testbench

- CPU output-port responder for the Blockade core. It is the write-side counterpart of the input multiplexer that serves IN0–IN2 reads.
- Decodes 8080 OUT cycles using the latched OUTP status strobe and the low address byte.
- Holds the coin latch and the sound-frequency register.
- Runs the tone divider and the envelope state machine, and produces an 8-bit mono audio sample for the top level.

---
 rtl/blockade_outport.sv | 175 +++++++++++++++++
 tb/tb_blockade_outport.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blockade_outport.sv
// blockade_outport
//   Write-side CPU port responder for the Blockade core. It decodes 8080 OUT
//   cycles, holds the coin latch and the sound-frequency register, runs the
//   tone divider and the envelope state machine, and produces an 8-bit mono
//   audio sample.
//
// Parameters
//   ENV_DIV   tick_en pulses per envelope decay step (>= 1)
//   ENV_MAX   envelope level loaded by an ENV_ON write
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   outp        OUT-cycle strobe (level; may stay high for many clocks)
//   port_addr   CPU ADDR[7:0] during the OUT cycle
//   data_in     CPU write data
//   tick_en     one-clock sound clock enable
//   coin_latch  coin latch bit
//   sound_freq  current frequency register
//   tone_out    divider square wave
//   env_level   current envelope level
//   env_busy    envelope state machine not idle
//   audio       registered sample: tone_out ? env_level : 0
module blockade_outport #(
   parameter int         ENV_DIV = 4096,
   parameter logic [7:0] ENV_MAX = 8'hFF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       outp,
   input  logic [7:0] port_addr,
   input  logic [7:0] data_in,
   input  logic       tick_en,
   output logic       coin_latch,
   output logic [7:0] sound_freq,
   output logic       tone_out,
   output logic [7:0] env_level,
   output logic       env_busy,
   output logic [7:0] audio
);

   localparam int PW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(ENV_DIV - 1);

   typedef enum logic [1:0] {
      ENV_IDLE  = 2'd0,
      ENV_HOLD  = 2'd1,
      ENV_DECAY = 2'd2
   } env_state_t;

   logic          outp_q;
   logic          wr_evt;
   logic          env_on;
   logic          env_off;
   logic [7:0]    tone_cnt;
   logic [PW-1:0] presc, presc_nxt;
   logic [7:0]    level_nxt;
   env_state_t    state, state_nxt;

   // Upper address bits carry no port selects on this board.
   logic unused_addr_hi;
   assign unused_addr_hi = ^port_addr[7:4];

   // One event per OUT cycle: rising edge of the strobe level.
   assign wr_evt  = outp & ~outp_q;
   assign env_on  = wr_evt & port_addr[2];
   assign env_off = wr_evt & port_addr[3];

   // outp_q sits at 1 during reset so a strobe still high at release is
   // treated as already seen and cannot fire a spurious write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) outp_q <= 1'b1;
      else          outp_q <= outp;
   end

   // Port registers. Several address bits may be set in one write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         coin_latch <= 1'b0;
         sound_freq <= 8'h00;
      end else if (wr_evt) begin
         if (port_addr[0]) coin_latch <= data_in[0];
         if (port_addr[1]) sound_freq <= data_in;
      end
   end

   // Tone divider: counts up to FF, then reloads from sound_freq, so the
   // half-period is 256 - sound_freq ticks. A frequency write only takes
   // effect at the next reload.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tone_cnt <= 8'h00;
         tone_out <= 1'b0;
      end else if (tick_en) begin
         if (tone_cnt == 8'hFF) begin
            tone_cnt <= sound_freq;
            tone_out <= ~tone_out;
         end else begin
            tone_cnt <= tone_cnt + 8'd1;
         end
      end
   end

   // Envelope state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ENV_IDLE;
         env_level <= 8'h00;
         presc     <= '0;
      end else begin
         state     <= state_nxt;
         env_level <= level_nxt;
         presc     <= presc_nxt;
      end
   end

   // Envelope next state. ENV_OFF beats ENV_ON in the same write; a
   // command write beats a coincident decay tick.
   always_comb begin
      state_nxt = state;
      level_nxt = env_level;
      presc_nxt = presc;
      case (state)
         ENV_IDLE: begin
            level_nxt = 8'h00;
            if (env_on && !env_off) begin
               state_nxt = ENV_HOLD;
               level_nxt = ENV_MAX;
               presc_nxt = '0;
            end
         end
         ENV_HOLD: begin
            if (env_off) begin
               state_nxt = ENV_DECAY;
               presc_nxt = '0;
            end else if (env_on) begin
               level_nxt = ENV_MAX;
               presc_nxt = '0;
            end
         end
         ENV_DECAY: begin
            if (env_on && !env_off) begin
               state_nxt = ENV_HOLD;
               level_nxt = ENV_MAX;
               presc_nxt = '0;
            end else if (env_level == 8'h00) begin
               // Only reachable with ENV_MAX of zero; never underflow.
               state_nxt = ENV_IDLE;
            end else if (tick_en) begin
               if (presc == PRESC_LAST) begin
                  presc_nxt = '0;
                  level_nxt = env_level - 8'd1;
                  if (env_level == 8'd1) state_nxt = ENV_IDLE;
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end
         end
         default: begin
            state_nxt = ENV_IDLE;
            level_nxt = 8'h00;
            presc_nxt = '0;
         end
      endcase
   end

   assign env_busy = (state != ENV_IDLE);

   // Audio sample follows the previous edge's tone and level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) audio <= 8'h00;
      else          audio <= tone_out ? env_level : 8'h00;
   end

endmodule

// File: tb/tb_blockade_outport.sv
module tb_blockade_outport;

   localparam int         DIV = 4;
   localparam logic [7:0] MAX = 8'h03;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       outp = 1'b1;
   logic [7:0] port_addr = 8'h00;
   logic [7:0] data_in = 8'h00;
   logic       tick_en = 1'b0;
   logic       coin_latch, tone_out, env_busy;
   logic [7:0] sound_freq, env_level, audio;

   int checks = 0;
   int passes = 0;

   blockade_outport #(.ENV_DIV(DIV), .ENV_MAX(MAX)) dut (
      .clk(clk), .reset_n(reset_n), .outp(outp), .port_addr(port_addr),
      .data_in(data_in), .tick_en(tick_en), .coin_latch(coin_latch),
      .sound_freq(sound_freq), .tone_out(tone_out), .env_level(env_level),
      .env_busy(env_busy), .audio(audio)
   );

   always #5 clk = ~clk;

   // Reference model: strobe history, registers, ticks left until the next
   // tone toggle, and the envelope as a mode plus ticks within a step.
   bit         m_oq;
   bit         m_coin;
   logic [7:0] m_freq;
   bit         m_tone;
   int         m_remain;
   int         m_level;
   int         m_mode;   // 0 idle, 1 hold, 2 decay
   int         m_ticks;
   logic [7:0] m_audio;

   task automatic model_reset();
      m_oq = 1; m_coin = 0; m_freq = 8'h00; m_tone = 0; m_remain = 256;
      m_level = 0; m_mode = 0; m_ticks = 0; m_audio = 8'h00;
   endtask

   task automatic model_edge();
      bit wr, on, off;
      if (!reset_n) begin
         model_reset();
         return;
      end
      wr  = outp && !m_oq;
      on  = wr && port_addr[2];
      off = wr && port_addr[3];
      m_audio = m_tone ? 8'(m_level) : 8'h00;
      if (tick_en) begin
         m_remain--;
         if (m_remain == 0) begin
            m_tone   = !m_tone;
            m_remain = 256 - int'(m_freq);
         end
      end
      if (off && m_mode == 1) begin
         m_mode = 2; m_ticks = 0;
      end else if (on && !off) begin
         m_mode = 1; m_level = int'(MAX); m_ticks = 0;
      end else if (m_mode == 2 && tick_en) begin
         m_ticks++;
         if (m_ticks == DIV) begin
            m_ticks = 0;
            m_level--;
            if (m_level == 0) m_mode = 0;
         end
      end
      if (wr && port_addr[0]) m_coin = data_in[0];
      if (wr && port_addr[1]) m_freq = data_in;
      m_oq = outp;
   endtask

   function automatic logic [26:0] dut_vec();
      return {coin_latch, sound_freq, tone_out, env_level, env_busy, audio};
   endfunction

   function automatic logic [26:0] mdl_vec();
      return {m_coin, m_freq, m_tone, 8'(m_level), m_mode != 0, m_audio};
   endfunction

   // One clock; inputs must be stable before the edge, outputs sampled 1 after.
   task automatic step(input bit t);
      tick_en = t;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // One-clock strobe followed by a low clock so the next write is a new event.
   task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit t);
      outp = 1'b1; port_addr = a; data_in = d;
      step(t);
      outp = 1'b0; port_addr = 8'h00;
      step(t);
   endtask

   // Ticks every clock until tone_out changes; -1 if it never does.
   task automatic wait_toggle(output int n);
      logic start;
      start = tone_out;
      n = -1;
      for (int i = 1; i <= 300; i++) begin
         step(1'b1);
         if (tone_out !== start) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0);
      checks++;
      if (dut_vec() !== 27'd0) $display("FAIL reset_state: got %h want 0", dut_vec());
      else passes++;
      reset_n = 1'b1;
      port_addr = 8'h03; data_in = 8'hFF;
      for (int i = 0; i < 4; i++) step(1'b0);
      checks++;
      if (coin_latch !== 1'b0 || sound_freq !== 8'h00)
         $display("FAIL reset_release_no_write: coin %b freq %h want 0 00", coin_latch, sound_freq);
      else passes++;
      outp = 1'b0;
      step(1'b0);
      wr(8'h01, 8'h01, 1'b0);
      checks++;
      if (coin_latch !== 1'b1) $display("FAIL coin_set: got %b want 1", coin_latch);
      else passes++;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
      else passes++;
   endtask

   task automatic test_long_strobe();
      int n;
      outp = 1'b1; port_addr = 8'h02; data_in = 8'h80;
      step(1'b0);
      data_in = 8'h33;  // a second event would capture this
      for (int i = 1; i < 20; i++) step(1'b0);
      outp = 1'b0; port_addr = 8'h00;
      step(1'b0);
      checks++;
      if (sound_freq !== 8'h80) $display("FAIL long_strobe_freq: got %h want 80", sound_freq);
      else passes++;
      wait_toggle(n);
      checks++;
      if (n !== 256) $display("FAIL first_period: got %0d want 256", n);
      else passes++;
      for (int k = 0; k < 2; k++) begin
         wait_toggle(n);
         checks++;
         if (n !== 128) $display("FAIL half_period_80: got %0d want 128", n);
         else passes++;
      end
   endtask

   task automatic test_divider();
      int n;
      wr(8'h02, 8'hFF, 1'b1);
      wait_toggle(n);
      for (int k = 0; k < 3; k++) begin
         wait_toggle(n);
         checks++;
         if (n !== 1) $display("FAIL half_period_ff: got %0d want 1", n);
         else passes++;
      end
      wr(8'h02, 8'h00, 1'b1);
      wait_toggle(n);
      wait_toggle(n);
      checks++;
      if (n !== 256) $display("FAIL half_period_00: got %0d want 256", n);
      else passes++;
      // Change frequency mid-count: old half-period finishes first.
      wr(8'h02, 8'h80, 1'b1);
      wait_toggle(n);
      wait_toggle(n);
      for (int i = 0; i < 10; i++) step(1'b1);
      wr(8'h02, 8'hC0, 1'b1);
      wait_toggle(n);
      checks++;
      if (n !== 116) $display("FAIL midcount_old_period: got %0d want 116", n);
      else passes++;
      wait_toggle(n);
      checks++;
      if (n !== 64) $display("FAIL midcount_new_period: got %0d want 64", n);
      else passes++;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL divider_model: got %h want %h", dut_vec(), mdl_vec());
      else passes++;
   endtask

   task automatic test_envelope();
      logic [7:0] lv;
      wr(8'h04, 8'h00, 1'b0);
      checks++;
      if (env_level !== MAX || env_busy !== 1'b1)
         $display("FAIL env_on: level %h busy %b want %h 1", env_level, env_busy, MAX);
      else passes++;
      wr(8'h08, 8'h00, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         step(1'b1);
         lv = MAX - 8'(k / DIV);
         checks++;
         if (env_level !== lv || env_busy !== (k < 12))
            $display("FAIL env_decay tick %0d: level %h busy %b want %h %b", k, env_level, env_busy, lv, k < 12);
         else passes++;
      end
   endtask

   task automatic test_conflicts();
      wr(8'h0C, 8'h00, 1'b0);
      checks++;
      if (env_level !== 8'h00 || env_busy !== 1'b0)
         $display("FAIL both_from_idle: level %h busy %b want 00 0", env_level, env_busy);
      else passes++;
      wr(8'h04, 8'h00, 1'b0);
      wr(8'h0C, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1);
      checks++;
      if (env_level !== 8'h02 || env_busy !== 1'b1)
         $display("FAIL both_from_hold: level %h busy %b want 02 1", env_level, env_busy);
      else passes++;
      for (int i = 0; i < 4; i++) step(1'b1);
      wr(8'h04, 8'h00, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1);
      checks++;
      if (env_level !== MAX || env_busy !== 1'b1)
         $display("FAIL on_during_decay: level %h busy %b want %h 1", env_level, env_busy, MAX);
      else passes++;
      wr(8'h08, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1);
      wr(8'h04, 8'h00, 1'b1);  // write lands on the tick that would decrement
      for (int i = 0; i < 4; i++) step(1'b1);
      checks++;
      if (env_level !== MAX) $display("FAIL write_beats_tick: level %h want %h", env_level, MAX);
      else passes++;
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL conflict_model: got %h want %h", dut_vec(), mdl_vec());
      else passes++;
   endtask

   task automatic test_random();
      int len;
      for (int i = 0; i < 80; i++) begin
         port_addr = 8'($urandom); data_in = 8'($urandom); outp = 1'b1;
         len = $urandom_range(1, 3);
         for (int j = 0; j < len; j++) begin
            step(1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL random_strobe %0d: got %h want %h", i, dut_vec(), mdl_vec());
            else passes++;
         end
         outp = 1'b0;
         len = $urandom_range(1, 20);
         for (int j = 0; j < len; j++) begin
            step(1'($urandom_range(0, 3) != 0));
            checks++;
            if (dut_vec() !== mdl_vec()) $display("FAIL random_idle %0d: got %h want %h", i, dut_vec(), mdl_vec());
            else passes++;
         end
      end
   endtask

   task automatic test_async_reset();
      wr(8'h02, 8'hFF, 1'b1);
      wr(8'h04, 8'h00, 1'b1);
      wr(8'h08, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) step(1'b1);
      checks++;
      if (env_busy !== 1'b1) $display("FAIL pre_reset_decay: busy %b want 1", env_busy);
      else passes++;
      outp = 1'b1; port_addr = 8'h0F; data_in = 8'hFF;
      reset_n = 1'b0;
      #2;
      checks++;
      if (dut_vec() !== 27'd0) $display("FAIL async_reset_clear: got %h want 0", dut_vec());
      else passes++;
      model_reset();
      step(1'b1);
      step(1'b1);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1);
      checks++;
      if (dut_vec() !== mdl_vec()) $display("FAIL post_reset_model: got %h want %h", dut_vec(), mdl_vec());
      else passes++;
      outp = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_long_strobe();
      test_divider();
      test_envelope();
      test_conflicts();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
